// File: rtl/pipeline_hazard_controller.sv
// Stall, flush and forwarding control for the 5-stage pipeline.
// Branch-flush and memory-wait sequencing with a stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int ADR_W       = 3,
  parameter int BR_PENALTY  = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [ADR_W-1:0] reg_read_adr1_d,
  input  logic [ADR_W-1:0] reg_read_adr2_d,
  input  logic [ADR_W-1:0] reg_read_adr1_e,
  input  logic [ADR_W-1:0] reg_read_adr2_e,
  input  logic             reg_write_e,
  input  logic [ADR_W-1:0] reg_write_adr_e,
  input  logic             mem_to_reg_e,
  input  logic             reg_write_m,
  input  logic [ADR_W-1:0] reg_write_adr_m,
  input  logic             reg_write_w,
  input  logic [ADR_W-1:0] reg_write_adr_w,
  input  logic             branch_taken_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_em,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_error,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEN_INIT =
    CNT_W'(BR_PENALTY - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX =
    CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] pen_q, pen_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             set_err;
  logic             mem_stall;
  logic             load_use;

  assign mem_stall = mem_req_m & ~mem_ready;

  assign load_use = reg_write_e & mem_to_reg_e &
    ((reg_write_adr_e == reg_read_adr1_d) |
     (reg_write_adr_e == reg_read_adr2_d));

  // Operand bypass select: M result wins over W result.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reset_n) begin
      if (reg_write_m &&
          reg_write_adr_m == reg_read_adr1_e)
        forward_a_e = 2'b10;
      else if (reg_write_w &&
               reg_write_adr_w == reg_read_adr1_e)
        forward_a_e = 2'b01;
      if (reg_write_m &&
          reg_write_adr_m == reg_read_adr2_e)
        forward_b_e = 2'b10;
      else if (reg_write_w &&
               reg_write_adr_w == reg_read_adr2_e)
        forward_b_e = 2'b01;
    end
  end

  // Next-state and stall/flush decode.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    state_d  = state_q;
    ret_d    = ret_q;
    pen_d    = pen_q;
    wait_d   = wait_q;
    set_err  = 1'b0;
    if (!reset_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
            ret_d    = RUN;
            wait_d   = ONE;
            state_d  = MEM_WAIT;
          end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (BR_PENALTY > 1) begin
              pen_d   = PEN_INIT;
              state_d = BR_FLUSH;
            end
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        BR_FLUSH: begin
          if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
            ret_d    = BR_FLUSH;
            wait_d   = ONE;
            state_d  = MEM_WAIT;
          end else begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            pen_d   = pen_q - ONE;
            if (pen_q == ONE)
              state_d = RUN;
          end
        end
        MEM_WAIT: begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_em = 1'b1;
          if (mem_ready) begin
            state_d = ret_q;
          end else if (wait_q == WAIT_MAX) begin
            set_err = 1'b1;
            state_d = ret_q;
          end else begin
            wait_d = wait_q + ONE;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, counters, sticky error and stall counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      pen_q        <= '0;
      wait_q       <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pen_q   <= pen_d;
      wait_q  <= wait_d;
      if (set_err)
        mem_error <= 1'b1;
      if (stall_f && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Random plus directed bench for pipeline_hazard_controller.
// Reference model tracks pending flushes and memory wait directly.
module tb_pipeline_hazard_controller;

  localparam int ADR_W = 3;
  localparam int BRP   = 2;
  localparam int TO    = 15;
  localparam int CNT_W = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset_n;
  logic [ADR_W-1:0] reg_read_adr1_d, reg_read_adr2_d;
  logic [ADR_W-1:0] reg_read_adr1_e, reg_read_adr2_e;
  logic             reg_write_e, mem_to_reg_e;
  logic [ADR_W-1:0] reg_write_adr_e;
  logic             reg_write_m;
  logic [ADR_W-1:0] reg_write_adr_m;
  logic             reg_write_w;
  logic [ADR_W-1:0] reg_write_adr_w;
  logic             branch_taken_e, mem_req_m, mem_ready;
  logic             stall_f, stall_d, stall_em;
  logic             flush_d, flush_e;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             mem_error;
  logic [15:0]      stall_cycles;

  pipeline_hazard_controller #(
    .ADR_W(ADR_W), .BR_PENALTY(BRP),
    .MEM_TIMEOUT(TO), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .reg_read_adr1_d(reg_read_adr1_d),
    .reg_read_adr2_d(reg_read_adr2_d),
    .reg_read_adr1_e(reg_read_adr1_e),
    .reg_read_adr2_e(reg_read_adr2_e),
    .reg_write_e(reg_write_e),
    .reg_write_adr_e(reg_write_adr_e),
    .mem_to_reg_e(mem_to_reg_e),
    .reg_write_m(reg_write_m),
    .reg_write_adr_m(reg_write_adr_m),
    .reg_write_w(reg_write_w),
    .reg_write_adr_w(reg_write_adr_w),
    .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_em(stall_em),
    .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e),
    .mem_error(mem_error),
    .stall_cycles(stall_cycles)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model state: remaining flush cycles, wait tracking.
  int m_pend   = 0;
  bit m_wait   = 0;
  int m_waited = 0;
  bit m_err    = 0;
  int m_cnt    = 0;

  function automatic logic [1:0] fwd(
      input logic [ADR_W-1:0] a);
    if (reg_write_m && reg_write_adr_m == a) return 2'b10;
    if (reg_write_w && reg_write_adr_w == a) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    bit ms, lu, sf, sd, se, fd, fe;
    logic [1:0] fa, fb;
    @(negedge clock);
    ms = mem_req_m & ~mem_ready;
    lu = reg_write_e & mem_to_reg_e &
         ((reg_write_adr_e == reg_read_adr1_d) |
          (reg_write_adr_e == reg_read_adr2_d));
    {sf, sd, se, fd, fe} = 5'b0;
    fa = 2'b00;
    fb = 2'b00;
    if (!reset_n) begin
      fd = 1; fe = 1;
    end else begin
      fa = fwd(reg_read_adr1_e);
      fb = fwd(reg_read_adr2_e);
      if (m_wait || ms) begin
        sf = 1; sd = 1; se = 1;
      end else if (m_pend > 0 || branch_taken_e) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    check("stall_f", 16'(stall_f), 16'(sf));
    check("stall_d", 16'(stall_d), 16'(sd));
    check("stall_em", 16'(stall_em), 16'(se));
    check("flush_d", 16'(flush_d), 16'(fd));
    check("flush_e", 16'(flush_e), 16'(fe));
    check("fwd_a", 16'(forward_a_e), 16'(fa));
    check("fwd_b", 16'(forward_b_e), 16'(fb));
    check("mem_error", 16'(mem_error), 16'(m_err));
    check("stall_cycles", stall_cycles, 16'(m_cnt));
    if (!reset_n) begin
      m_pend = 0; m_wait = 0; m_waited = 0;
      m_err = 0; m_cnt = 0;
    end else begin
      if (sf && m_cnt < 65535) m_cnt++;
      if (m_wait) begin
        if (mem_ready) m_wait = 0;
        else if (m_waited == TO) begin
          m_err = 1; m_wait = 0;
        end else m_waited++;
      end else if (ms) begin
        m_wait = 1; m_waited = 1;
      end else if (m_pend > 0) begin
        m_pend--;
      end else if (branch_taken_e) begin
        m_pend = BRP - 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    reg_read_adr1_d = 0; reg_read_adr2_d = 0;
    reg_read_adr1_e = 0; reg_read_adr2_e = 0;
    reg_write_e = 0; mem_to_reg_e = 0;
    reg_write_adr_e = 0;
    reg_write_m = 0; reg_write_adr_m = 0;
    reg_write_w = 0; reg_write_adr_w = 0;
    branch_taken_e = 0; mem_req_m = 0;
    mem_ready = 1;
  endtask

  task automatic randomize_in();
    reg_read_adr1_d = ADR_W'($urandom);
    reg_read_adr2_d = ADR_W'($urandom);
    reg_read_adr1_e = ADR_W'($urandom);
    reg_read_adr2_e = ADR_W'($urandom);
    reg_write_e     = 1'($urandom);
    mem_to_reg_e    = 1'($urandom);
    reg_write_adr_e = ADR_W'($urandom);
    reg_write_m     = 1'($urandom);
    reg_write_adr_m = ADR_W'($urandom);
    reg_write_w     = 1'($urandom);
    reg_write_adr_w = ADR_W'($urandom);
    branch_taken_e  = ($urandom_range(0, 5) == 0);
    mem_req_m       = ($urandom_range(0, 3) == 0);
    mem_ready       = ($urandom_range(0, 2) != 0);
    reset_n         = ($urandom_range(0, 59) != 0);
  endtask

  int base;

  initial begin
    clear_in();
    reset_n = 0;
    #1;
    step();
    step();
    reset_n = 1;
    step();

    reg_write_e = 1; mem_to_reg_e = 1;
    reg_write_adr_e = 3; reg_read_adr1_d = 3;
    step();
    reg_write_e = 0; mem_to_reg_e = 0;
    reg_write_m = 1; reg_write_adr_m = 3;
    reg_read_adr1_e = 3;
    step();
    clear_in();
    step();

    reg_write_m = 1; reg_write_adr_m = 2;
    reg_write_w = 1; reg_write_adr_w = 2;
    reg_read_adr1_e = 2; reg_read_adr2_e = 2;
    step();
    reg_write_m = 0;
    step();
    clear_in();

    branch_taken_e = 1;
    step();
    branch_taken_e = 0;
    step();
    step();

    base = m_cnt;
    mem_req_m = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1;
    step();
    mem_req_m = 0;
    step();
    check("mem_wait_cnt", stall_cycles, 16'(base + 4));
    check("no_err", 16'(mem_error), 16'd0);

    mem_req_m = 1; mem_ready = 0;
    repeat (TO + 1) step();
    mem_req_m = 0; mem_ready = 1;
    step();
    check("timeout_err", 16'(mem_error), 16'd1);
    repeat (3) step();
    check("err_sticky", 16'(mem_error), 16'd1);

    branch_taken_e = 1;
    step();
    branch_taken_e = 0;
    mem_req_m = 1; mem_ready = 0;
    step();
    step();
    mem_ready = 1;
    step();
    mem_req_m = 0;
    step();
    step();

    mem_req_m = 1; mem_ready = 0;
    repeat (3) step();
    reset_n = 0;
    step();
    reset_n = 1; mem_req_m = 0; mem_ready = 1;
    step();
    check("rst_mid_err", 16'(mem_error), 16'd0);
    check("rst_mid_em", 16'(stall_em), 16'd0);

    repeat (4000) begin
      randomize_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
